// File: rtl/inter_arb_pkg.sv
// Shared types, constants and field-slice helpers for the inter_arb interconnect.
// A request word is packed {sel, addr, value} with value in the least-significant bits.
package inter_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Helpers take the request zero-extended to MAX_W; request words wider than this are
  // not supported.
  localparam int unsigned MAX_W = 64;

  function automatic logic [31:0] get_sel(input logic [MAX_W-1:0] data,
                                          input int unsigned sel_w,
                                          input int unsigned addr_w,
                                          input int unsigned val_w);
    logic [MAX_W-1:0] sh;
    logic [MAX_W-1:0] mask;
    sh   = data >> (addr_w + val_w);
    mask = (MAX_W'(1) << sel_w) - MAX_W'(1);
    return 32'(sh & mask);
  endfunction

  function automatic logic [31:0] get_addr(input logic [MAX_W-1:0] data,
                                           input int unsigned addr_w,
                                           input int unsigned val_w);
    logic [MAX_W-1:0] sh;
    logic [MAX_W-1:0] mask;
    sh   = data >> val_w;
    mask = (MAX_W'(1) << addr_w) - MAX_W'(1);
    return 32'(sh & mask);
  endfunction

  function automatic logic [31:0] get_val(input logic [MAX_W-1:0] data,
                                          input int unsigned val_w);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << val_w) - MAX_W'(1);
    return 32'(data & mask);
  endfunction

endpackage

// File: rtl/inter_arb_rr_arbiter.sv
// Combinational arbiter shared by both arbitration modes.
//   i_req   : pending request per master
//   i_ptr   : index of the master served last (round-robin only)
//   i_mode  : 0 = fixed priority (index 0 highest), 1 = round-robin
//   o_grant : one-hot grant
//   o_idx   : index of the granted master
//   o_valid : at least one request pending
module inter_arb_rr_arbiter
  import inter_arb_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_mode,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    int unsigned j;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Round-robin scans starting just after the last-served master, wrapping.
      if (i_mode == 1'(ARB_RR)) begin
        j = (32'(i_ptr) + 32'd1 + k) % N;
      end else begin
        j = k;
      end
      if (!o_valid && i_req[j]) begin
        o_valid    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/inter_arb.sv
// N-master / M-slave single-beat interconnect.
// Each master has a one-entry request buffer; a pending request is granted (fixed priority
// or round-robin), its {sel, addr, value} is routed to the selected slave with a
// valid/ready handshake, and a one-cycle pulse reports either the completed handshake or
// a request whose sel does not name an existing slave.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/in_ready/data_in : per-master request capture (in_ready = buffer empty)
//   ready_slave/valid_slave   : per-slave handshake; valid_slave is one-hot
//   addr_out/value_out        : fields of the request being served
//   handshake_slave           : pulse on the cycle after a slave handshake
//   grant_id                  : master currently being served
//   decode_err                : pulse when a granted request had sel >= NUM_SLAVE
module inter_arb
  import inter_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTER = 3,
  parameter int unsigned NUM_SLAVE  = 2,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned VAL_W      = 3,
  parameter int unsigned ARB_MODE   = 0,
  localparam int unsigned SEL_W  = $clog2(NUM_SLAVE),
  localparam int unsigned DATA_W = SEL_W + ADDR_W + VAL_W,
  localparam int unsigned GID_W  = $clog2(NUM_MASTER)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MASTER-1:0]        in_valid,
  input  logic [NUM_MASTER*DATA_W-1:0] data_in,
  output logic [NUM_MASTER-1:0]        in_ready,
  input  logic [NUM_SLAVE-1:0]         ready_slave,
  output logic [NUM_SLAVE-1:0]         valid_slave,
  output logic [ADDR_W-1:0]            addr_out,
  output logic [VAL_W-1:0]             value_out,
  output logic [NUM_SLAVE-1:0]         handshake_slave,
  output logic [GID_W-1:0]             grant_id,
  output logic                         decode_err
);

  state_e                r_state;
  logic [NUM_MASTER-1:0] r_pend;
  logic [DATA_W-1:0]     r_buf [NUM_MASTER];
  logic [GID_W-1:0]      r_ptr;
  logic [NUM_SLAVE-1:0]  r_valid_slave;
  logic [ADDR_W-1:0]     r_addr;
  logic [VAL_W-1:0]      r_val;
  logic [NUM_SLAVE-1:0]  r_hs;
  logic [GID_W-1:0]      r_grant;
  logic                  r_derr;

  state_e                w_state_nxt;
  logic [NUM_MASTER-1:0] w_pend_nxt;
  logic [NUM_MASTER-1:0] w_clr;
  logic [GID_W-1:0]      w_ptr_nxt;
  logic [NUM_SLAVE-1:0]  w_vs_nxt;
  logic [ADDR_W-1:0]     w_addr_nxt;
  logic [VAL_W-1:0]      w_val_nxt;
  logic [NUM_SLAVE-1:0]  w_hs_nxt;
  logic [GID_W-1:0]      w_grant_nxt;
  logic                  w_derr_nxt;

  logic [NUM_MASTER-1:0] w_arb_grant;
  logic [GID_W-1:0]      w_arb_idx;
  logic                  w_arb_valid;
  logic [DATA_W-1:0]     w_gbuf;
  logic [31:0]           w_sel;
  logic                  w_sel_ok;
  logic [NUM_SLAVE-1:0]  w_hs_hit;

  inter_arb_rr_arbiter #(
    .N (NUM_MASTER)
  ) u_arb (
    .i_req   (r_pend),
    .i_ptr   (r_ptr),
    .i_mode  (1'(ARB_MODE)),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_gbuf   = r_buf[w_arb_idx];
  assign w_sel    = get_sel(MAX_W'(w_gbuf), SEL_W, ADDR_W, VAL_W);
  // Codes beyond NUM_SLAVE-1 only exist when NUM_SLAVE is not a power of two.
  assign w_sel_ok = (w_sel < NUM_SLAVE);
  // Only the selected slave's ready matters: valid_slave is one-hot.
  assign w_hs_hit = r_valid_slave & ready_slave;

  assign in_ready        = ~r_pend;
  assign valid_slave     = r_valid_slave;
  assign addr_out        = r_addr;
  assign value_out       = r_val;
  assign handshake_slave = r_hs;
  assign grant_id        = r_grant;
  assign decode_err      = r_derr;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_vs_nxt    = r_valid_slave;
    w_addr_nxt  = r_addr;
    w_val_nxt   = r_val;
    w_grant_nxt = r_grant;
    w_hs_nxt    = '0;
    w_derr_nxt  = 1'b0;
    w_clr       = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          if (w_sel_ok) begin
            w_state_nxt = SEND;
            w_vs_nxt    = NUM_SLAVE'(1) << w_sel;
            w_addr_nxt  = ADDR_W'(get_addr(MAX_W'(w_gbuf), ADDR_W, VAL_W));
            w_val_nxt   = VAL_W'(get_val(MAX_W'(w_gbuf), VAL_W));
            w_grant_nxt = w_arb_idx;
          end else begin
            // Drop the undeliverable request; it still counts as served for round-robin.
            w_derr_nxt = 1'b1;
            w_clr      = w_arb_grant;
            w_ptr_nxt  = w_arb_idx;
          end
        end
      end
      SEND: begin
        if (|w_hs_hit) begin
          w_state_nxt = IDLE;
          w_hs_nxt    = w_hs_hit;
          w_vs_nxt    = '0;
          w_addr_nxt  = '0;
          w_val_nxt   = '0;
          w_clr       = NUM_MASTER'(1) << r_grant;
          w_ptr_nxt   = r_grant;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Set and clear never collide: capture needs pend=0, clear needs pend=1.
    w_pend_nxt = (r_pend & ~w_clr) | (in_valid & ~r_pend);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pend        <= '0;
      r_ptr         <= GID_W'(NUM_MASTER - 1);
      r_valid_slave <= '0;
      r_addr        <= '0;
      r_val         <= '0;
      r_hs          <= '0;
      r_grant       <= '0;
      r_derr        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend        <= w_pend_nxt;
      r_ptr         <= w_ptr_nxt;
      r_valid_slave <= w_vs_nxt;
      r_addr        <= w_addr_nxt;
      r_val         <= w_val_nxt;
      r_hs          <= w_hs_nxt;
      r_grant       <= w_grant_nxt;
      r_derr        <= w_derr_nxt;
    end
  end

  // A buffer only loads while empty, so a pending request is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_MASTER; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTER; i++) begin
        if (in_valid[i] && !r_pend[i]) begin
          r_buf[i] <= data_in[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_inter_arb.sv
module tb_inter_arb;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // A: fixed priority, 3x2
  logic [2:0]  in_valid_a;
  logic [20:0] data_in_a;
  logic [2:0]  in_ready_a;
  logic [1:0]  ready_a, valid_a, hs_a;
  logic [2:0]  addr_a, val_a;
  logic [1:0]  gid_a;
  logic        derr_a;
  // B: round-robin, 3x2
  logic [2:0]  in_valid_b;
  logic [20:0] data_in_b;
  logic [2:0]  in_ready_b;
  logic [1:0]  ready_b, valid_b, hs_b;
  logic [2:0]  addr_b, val_b;
  logic [1:0]  gid_b;
  logic        derr_b;
  // C: fixed priority, 3x3 (sel is 2 bits, code 3 is out of range)
  logic [2:0]  in_valid_c;
  logic [23:0] data_in_c;
  logic [2:0]  in_ready_c, ready_c, valid_c, hs_c;
  logic [2:0]  addr_c, val_c;
  logic [1:0]  gid_c;
  logic        derr_c;

  typedef struct packed {
    logic [1:0] vs;
    logic [2:0] addr;
    logic [2:0] val;
    logic [1:0] gid;
  } exp_t;

  typedef struct {
    int         m;
    logic [6:0] data;
    logic [1:0] vs;
    logic [2:0] addr;
    logic [2:0] val;
  } vec_t;

  exp_t       sb_a[$];
  logic [1:0] exp_hs_a;
  int         gb_q[$];
  vec_t       vecs[6];

  inter_arb #(.NUM_MASTER(3), .NUM_SLAVE(2), .ADDR_W(3), .VAL_W(3), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .data_in(data_in_a), .in_ready(in_ready_a),
    .ready_slave(ready_a), .valid_slave(valid_a), .addr_out(addr_a), .value_out(val_a),
    .handshake_slave(hs_a), .grant_id(gid_a), .decode_err(derr_a)
  );

  inter_arb #(.NUM_MASTER(3), .NUM_SLAVE(2), .ADDR_W(3), .VAL_W(3), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .data_in(data_in_b), .in_ready(in_ready_b),
    .ready_slave(ready_b), .valid_slave(valid_b), .addr_out(addr_b), .value_out(val_b),
    .handshake_slave(hs_b), .grant_id(gid_b), .decode_err(derr_b)
  );

  inter_arb #(.NUM_MASTER(3), .NUM_SLAVE(3), .ADDR_W(3), .VAL_W(3), .ARB_MODE(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .data_in(data_in_c), .in_ready(in_ready_c),
    .ready_slave(ready_c), .valid_slave(valid_c), .addr_out(addr_c), .value_out(val_c),
    .handshake_slave(hs_c), .grant_id(gid_c), .decode_err(derr_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard for A: each completed handshake pops the next expected transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_hs_a = 2'b00;
    end else begin
      chk("hs_a", 32'(hs_a), 32'(exp_hs_a));
      chk("derr_a", 32'(derr_a), 32'd0);
      exp_hs_a = 2'b00;
      if (|(valid_a & ready_a)) begin
        if (sb_a.size() == 0) begin
          chk("unexpected_xfer_a", 32'(valid_a), 32'd0);
        end else begin
          e = sb_a.pop_front();
          chk("sb_valid", 32'(valid_a), 32'(e.vs));
          chk("sb_addr", 32'(addr_a), 32'(e.addr));
          chk("sb_val", 32'(val_a), 32'(e.val));
          chk("sb_gid", 32'(gid_a), 32'(e.gid));
          exp_hs_a = e.vs;
        end
      end
    end
  end

  task automatic req_a(input int m, input logic [6:0] d, input exp_t e);
    data_in_a[m*7 +: 7] = d;
    in_valid_a[m]       = 1'b1;
    sb_a.push_back(e);
  endtask

  task automatic wait_idle_a(input string name);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb_a.size() == 0 && valid_a == 2'b00) break;
    end
    chk(name, 32'(k < 60), 32'd1);
  endtask

  task automatic wait_valid_a(input string name, input logic [1:0] exp_vs);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valid_a != 2'b00) break;
    end
    chk(name, 32'(valid_a), 32'(exp_vs));
  endtask

  initial begin
    int rem[3];
    rst        = 1'b1;
    in_valid_a = '0; data_in_a = '0; ready_a = 2'b11;
    in_valid_b = '0; data_in_b = '0; ready_b = 2'b11;
    in_valid_c = '0; data_in_c = '0; ready_c = 3'b111;

    vecs[0] = '{m: 0, data: 7'b1_101_011, vs: 2'b10, addr: 3'd5, val: 3'd3};
    vecs[1] = '{m: 1, data: 7'b0_000_000, vs: 2'b01, addr: 3'd0, val: 3'd0};
    vecs[2] = '{m: 2, data: 7'b1_111_111, vs: 2'b10, addr: 3'd7, val: 3'd7};
    vecs[3] = '{m: 0, data: 7'b0_010_101, vs: 2'b01, addr: 3'd2, val: 3'd5};
    vecs[4] = '{m: 2, data: 7'b0_110_001, vs: 2'b01, addr: 3'd6, val: 3'd1};
    vecs[5] = '{m: 1, data: 7'b1_001_110, vs: 2'b10, addr: 3'd1, val: 3'd6};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_a), 32'h7);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_val", 32'(val_a), 32'd0);
    chk("rst_hs", 32'(hs_a), 32'd0);
    chk("rst_gid", 32'(gid_a), 32'd0);
    chk("rst_derr", 32'(derr_a), 32'd0);
    chk("rst_in_ready_c", 32'(in_ready_c), 32'h7);
    #1 rst = 1'b0;

    // Single request, cycle-exact latency
    @(posedge clk); #1;
    req_a(0, 7'b1_101_011, '{vs: 2'b10, addr: 3'd5, val: 3'd3, gid: 2'd0});
    @(posedge clk); #1;
    in_valid_a = '0;
    @(negedge clk);
    chk("t1_in_ready_t1", 32'(in_ready_a), 32'b110);
    chk("t1_valid_t1", 32'(valid_a), 32'd0);
    @(negedge clk);
    chk("t1_valid_t2", 32'(valid_a), 32'b10);
    chk("t1_addr_t2", 32'(addr_a), 32'd5);
    chk("t1_val_t2", 32'(val_a), 32'd3);
    @(negedge clk);
    chk("t1_hs_t3", 32'(hs_a), 32'b10);
    chk("t1_in_ready_t3", 32'(in_ready_a), 32'b111);
    chk("t1_valid_t3", 32'(valid_a), 32'd0);

    // Table-driven single transfers
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_a(vecs[i].m, vecs[i].data,
            '{vs: vecs[i].vs, addr: vecs[i].addr, val: vecs[i].val, gid: 2'(vecs[i].m)});
      @(posedge clk); #1;
      in_valid_a = '0;
      wait_idle_a("vec_done");
      chk("vec_in_ready", 32'(in_ready_a), 32'b111);
    end

    // Fixed priority: all three at once
    @(posedge clk); #1;
    req_a(0, {1'b0, 3'b001, 3'b010}, '{vs: 2'b01, addr: 3'd1, val: 3'd2, gid: 2'd0});
    req_a(1, {1'b1, 3'b011, 3'b100}, '{vs: 2'b10, addr: 3'd3, val: 3'd4, gid: 2'd1});
    req_a(2, {1'b0, 3'b110, 3'b111}, '{vs: 2'b01, addr: 3'd6, val: 3'd7, gid: 2'd2});
    @(posedge clk); #1;
    in_valid_a = '0;
    wait_idle_a("prio_done");

    // Back-pressure; re-request from busy master ignored, other master captured
    @(posedge clk); #1;
    ready_a = 2'b00;
    req_a(1, {1'b1, 3'b100, 3'b001}, '{vs: 2'b10, addr: 3'd4, val: 3'd1, gid: 2'd1});
    @(posedge clk); #1;
    in_valid_a = '0;
    wait_valid_a("bp_valid_up", 2'b10);
    @(posedge clk); #1;
    data_in_a[7 +: 7]  = 7'b0_111_111;
    data_in_a[14 +: 7] = {1'b0, 3'b010, 3'b011};
    in_valid_a = 3'b110;
    sb_a.push_back('{vs: 2'b01, addr: 3'd2, val: 3'd3, gid: 2'd2});
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(valid_a), 32'b10);
      chk("bp_addr", 32'(addr_a), 32'd4);
      chk("bp_val", 32'(val_a), 32'd1);
      chk("bp_gid", 32'(gid_a), 32'd1);
      chk("bp_in_ready1", 32'(in_ready_a[1]), 32'd0);
      @(posedge clk); #1;
      in_valid_a = '0;
    end
    ready_a = 2'b11;
    wait_idle_a("bp_done");
    repeat (3) begin
      @(negedge clk);
      chk("bp_quiet", 32'(valid_a), 32'd0);
    end
    chk("bp_in_ready", 32'(in_ready_a), 32'b111);

    // Round-robin on B: masters 0 and 2 re-request when served, master 1 once
    gb_q = '{0, 1, 2, 0, 2, 0};
    rem  = '{2, 0, 1};
    @(posedge clk); #1;
    data_in_b = {1'b0, 3'b011, 3'b011, 1'b1, 3'b010, 3'b010, 1'b0, 3'b001, 3'b001};
    in_valid_b = 3'b111;
    @(posedge clk); #1;
    in_valid_b = '0;
    for (int k = 0; k < 6; k++) begin
      int w;
      int e;
      for (w = 0; w < 20; w++) begin
        @(negedge clk);
        if (|(valid_b & ready_b)) break;
      end
      chk("rr_xfer_seen", 32'(w < 20), 32'd1);
      if (w < 20) begin
        e = gb_q.pop_front();
        chk("rr_grant", 32'(gid_b), 32'(e));
        chk("rr_addr", 32'(addr_b), 32'(e + 1));
        @(posedge clk); #1;
        if (rem[e] > 0) begin
          chk("rr_in_ready", 32'(in_ready_b[e]), 32'd1);
          in_valid_b[e] = 1'b1;
          rem[e]--;
          @(posedge clk); #1;
          in_valid_b = '0;
        end
      end
    end
    repeat (3) @(negedge clk);
    chk("rr_quiet", 32'(valid_b), 32'd0);

    // Decode error on C: sel=3 dropped, then masters 1 and 2 served
    @(posedge clk); #1;
    data_in_c = {2'b10, 3'b111, 3'b010, 2'b01, 3'b101, 3'b110, 2'b11, 3'b001, 3'b001};
    in_valid_c = 3'b111;
    @(posedge clk); #1;
    in_valid_c = '0;
    @(negedge clk);
    chk("de_derr_t1", 32'(derr_c), 32'd0);
    chk("de_in_ready_t1", 32'(in_ready_c), 32'b000);
    @(negedge clk);
    chk("de_derr_t2", 32'(derr_c), 32'd1);
    chk("de_valid_t2", 32'(valid_c), 32'd0);
    chk("de_in_ready_t2", 32'(in_ready_c), 32'b001);
    @(negedge clk);
    chk("de_derr_t3", 32'(derr_c), 32'd0);
    chk("de_valid_t3", 32'(valid_c), 32'b010);
    chk("de_addr_t3", 32'(addr_c), 32'd5);
    chk("de_val_t3", 32'(val_c), 32'd6);
    chk("de_gid_t3", 32'(gid_c), 32'd1);
    @(negedge clk);
    chk("de_hs_t4", 32'(hs_c), 32'b010);
    chk("de_valid_t4", 32'(valid_c), 32'd0);
    @(negedge clk);
    chk("de_valid_t5", 32'(valid_c), 32'b100);
    chk("de_addr_t5", 32'(addr_c), 32'd7);
    chk("de_gid_t5", 32'(gid_c), 32'd2);
    @(negedge clk);
    chk("de_hs_t6", 32'(hs_c), 32'b100);
    chk("de_in_ready_t6", 32'(in_ready_c), 32'b111);

    // Reset in the middle of SEND
    @(posedge clk); #1;
    ready_a = 2'b00;
    req_a(0, {1'b1, 3'b011, 3'b010}, '{vs: 2'b10, addr: 3'd3, val: 3'd2, gid: 2'd0});
    @(posedge clk); #1;
    in_valid_a = '0;
    wait_valid_a("mr_valid_up", 2'b10);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(valid_a), 32'd0);
    chk("mr_addr", 32'(addr_a), 32'd0);
    chk("mr_val", 32'(val_a), 32'd0);
    chk("mr_in_ready", 32'(in_ready_a), 32'b111);
    chk("mr_hs", 32'(hs_a), 32'd0);
    sb_a.delete();
    ready_a = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mr_no_hs", 32'(hs_a), 32'd0);
      chk("mr_idle_valid", 32'(valid_a), 32'd0);
    end
    @(posedge clk); #1;
    req_a(2, 7'b1_010_110, '{vs: 2'b10, addr: 3'd2, val: 3'd6, gid: 2'd2});
    @(posedge clk); #1;
    in_valid_a = '0;
    wait_idle_a("mr_after_done");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
